// File: rtl/wb_itf_pkg.sv
// Shared Wishbone (pipelined) bus types used by initiators and responders.
// Latency: n/a (types and widths only).
// Backpressure: stall in wb_output_t holds a request; ack completes it.
package wb_itf;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int SEL_WIDTH  = DATA_WIDTH / 8;

  // Initiator -> responder request bundle.
  typedef struct packed {
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [SEL_WIDTH-1:0]  sel;
  } wb_input_t;

  // Responder -> initiator return bundle.
  typedef struct packed {
    logic                  ack;
    logic                  stall;
    logic [DATA_WIDTH-1:0] data;
  } wb_output_t;

endpackage

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone pipelined initiator: one command in, one bus cycle out, one response back.
// Latency: accept N -> stb N+1 -> ack N+2 -> rsp_valid N+3 -> next accept N+4 at zero stall.
// Backpressure: cmd_ready only in IDLE; stb held with stable fields while stall; timeout after TIMEOUT_CYCLES.
//
// Ports:
//   wb_clk, wb_reset_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake; cmd_we/addr/data/sel latched on accept
//   rsp_valid/rsp_data/rsp_err   one-cycle completion pulse; data/err held until next completion
//   m_wb_o / m_wb_i              registered bus request / responder return
module wb_initiator
  import wb_itf::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  wb_clk,
  input  logic                  wb_reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [SEL_WIDTH-1:0]  cmd_sel,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output wb_input_t             m_wb_o,
  input  wb_output_t            m_wb_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Last count value before the timeout edge: the edge that would make the
  // count reach TIMEOUT_CYCLES abandons the transaction instead.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_ACK,
    RESP
  } state_e;

  state_e                state_q, state_d;
  wb_input_t             wb_q, wb_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  cmd_ready_q;
  logic                  rsp_valid_q;

  always_comb begin
    state_d    = state_q;
    wb_d       = wb_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Gate on the registered ready so nothing is taken on the first
        // cycle after reset release.
        if (cmd_valid && cmd_ready_q) begin
          wb_d.cyc  = 1'b1;
          wb_d.stb  = 1'b1;
          wb_d.we   = cmd_we;
          wb_d.addr = cmd_addr;
          wb_d.data = cmd_we ? cmd_data : '0;
          wb_d.sel  = cmd_sel;
          state_d   = REQ;
        end
      end

      REQ: begin
        // An ack only belongs to this request once the request has been
        // taken, i.e. on an edge where stall is low.
        if (!m_wb_i.stall && m_wb_i.ack) begin
          wb_d       = '0;
          cnt_d      = '0;
          rsp_data_d = wb_q.we ? '0 : m_wb_i.data;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (cnt_q == CNT_LAST) begin
          wb_d       = '0;
          cnt_d      = '0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!m_wb_i.stall) begin
            wb_d.stb = 1'b0;
            state_d  = WAIT_ACK;
          end
        end
      end

      WAIT_ACK: begin
        if (m_wb_i.ack) begin
          wb_d       = '0;
          cnt_d      = '0;
          rsp_data_d = wb_q.we ? '0 : m_wb_i.data;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (cnt_q == CNT_LAST) begin
          wb_d       = '0;
          cnt_d      = '0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        wb_d    = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_reset_n) begin
    if (!wb_reset_n) begin
      state_q     <= IDLE;
      wb_q        <= '0;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_q        <= wb_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      // Registered handshake flags track the state being entered, which keeps
      // them low throughout reset and aligned with the state afterwards.
      cmd_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RESP);
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign m_wb_o    = wb_q;

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of cycles from cyc assertion to ack before the transaction is abandoned.
REQ-002 SHALL have port wb_clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port wb_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 SHALL have port cmd_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr  input  ADDR_WIDTH  byte address.
REQ-008 SHALL have port cmd_data  input  DATA_WIDTH  write data.
REQ-009 SHALL have port cmd_sel  input  SEL_WIDTH  byte select.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_data  output  DATA_WIDTH  read data; 0 for writes and errors.
REQ-012 SHALL have port rsp_err  output  1  completion was a timeout.
REQ-013 SHALL have port m_wb_o  output  wb_input_t  cyc/stb/we/addr/data/sel driven to a responder port.
REQ-014 SHALL have port m_wb_i  input  wb_output_t  ack/stall/data returned by the responder.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT_ACK, RESP; one transaction outstanding at most.
REQ-016 SHALL drive cmd_ready = 1 only in IDLE; cmd_valid && cmd_ready latches we/addr/data/sel and moves to REQ.
REQ-017 SHALL drive cyc = stb = 1 in REQ with the latched fields, all m_wb_o outputs registered; REQ begins the cycle after acceptance.
REQ-018 SHALL hold stb and all fields stable in REQ while m_wb_i.stall = 1 (Wishbone pipelined mode).
REQ-019 SHALL, on a REQ edge with stall = 0, drop stb and move to WAIT_ACK with cyc held at 1; if ack is also sampled on that edge, go directly to RESP.
REQ-020 SHALL, in WAIT_ACK, on ack = 1 drop cyc, capture m_wb_i.data for reads (0 for writes), and go to RESP.
REQ-021 SHALL, in RESP, assert rsp_valid for exactly one cycle and return to IDLE; rsp_data and rsp_err hold until the next completion.
REQ-022 SHALL count cycles with cyc = 1 in a counter sized $clog2(TIMEOUT_CYCLES+1); on reaching TIMEOUT_CYCLES without ack, drop cyc and stb, go to RESP with rsp_err = 1 and rsp_data = 0.
REQ-023 SHALL ignore ack received in IDLE or RESP, and SHALL ignore stall outside REQ.
REQ-024 SHALL give a zero-stall, next-cycle-ack transaction: accept at edge N, stb at N+1, ack at N+2, rsp_valid at N+3; next cmd_ready at N+4.
REQ-025 SHALL drive m_wb_o.data = 0 for reads.

Reset
REQ-026 SHALL, on wb_reset_n low, immediately force IDLE, m_wb_o = 0, cmd_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, and counter = 0, even mid-transaction.
REQ-027 SHALL drive cmd_ready = 1 from the first rising edge after reset release; no pending response survives reset.

Structure
REQ-028 SHALL take wb_input_t, wb_output_t, ADDR_WIDTH, DATA_WIDTH and SEL_WIDTH from the shared wb_itf package, adding no new package types.
REQ-029 SHALL keep the FSM state enum local to the module; the block has no sub-modules.

Verification
REQ-030 SHALL cover: initiator on wb_ram port A, write 0x04 = 0xcafebabe, sel 4'hF -> rsp_err = 0 and RAM word 1 = 0xcafebabe; then read 0x04 -> rsp_data = 0xcafebabe.
REQ-031 SHALL cover: write 0xffffffff, then write 0x01020304 with sel 4'b0101 at 0x10, then read -> 0xff02ff04.
REQ-032 SHALL cover: two initiators on ports A/B issuing writes the same cycle -> exactly one sees stall, stb held stable; both complete with rsp_err = 0 and correct RAM contents.
REQ-033 SHALL cover: responder model holding ack = 0 -> rsp_valid with rsp_err = 1, rsp_data = 0 exactly 16 cycles after cyc rises; cyc = 0 afterwards.
REQ-034 SHALL cover: wb_reset_n pulsed low during WAIT_ACK -> cyc/stb = 0 in the same cycle, no rsp_valid, cmd_ready = 1 on the first edge after release.
REQ-035 SHALL cover: back-to-back read commands with cmd_valid held high -> each accepted exactly every 4 cycles at zero stall, responses in order.
